// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver. Deserialises NUM_WORDS consecutive frames,
//               LSB first with word 0 first, into one W_OUT-bit word. The
//               word is presented on a valid/ready master port. Pulses
//               frame_err on a bad first stop bit and overrun when a new
//               word is dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int  CLOCKS_PER_PULSE = 4,
  parameter int  BITS_PER_WORD    = 8,
  parameter int  PACKET_SIZE      = BITS_PER_WORD + 5,
  parameter int  W_OUT            = 24,
  localparam int NUM_WORDS        = W_OUT / BITS_PER_WORD
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic                                     rx,
  output logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]  m_data,
  output logic                                     m_valid,
  input  logic                                     m_ready,
  output logic                                     frame_err,
  output logic                                     overrun
);

  localparam int HALF = CLOCKS_PER_PULSE / 2;
  localparam int CW   = $clog2(CLOCKS_PER_PULSE);
  localparam int BW   = $clog2(BITS_PER_WORD);
  localparam int WW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [CW-1:0] c_HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] c_BIT_LAST  = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0] c_DATA_LAST = BW'(BITS_PER_WORD - 1);
  localparam logic [WW-1:0] c_WORD_LAST = WW'(NUM_WORDS - 1);

  // Reject configurations the counters and framing cannot represent.
  if (CLOCKS_PER_PULSE < 4) begin : g_bad_clocks_per_pulse
    $error("uart_rx: CLOCKS_PER_PULSE must be at least 4");
  end
  if (BITS_PER_WORD < 2 || (W_OUT % BITS_PER_WORD) != 0) begin : g_bad_word_shape
    $error("uart_rx: W_OUT must be a multiple of BITS_PER_WORD (>=2)");
  end
  if (PACKET_SIZE < BITS_PER_WORD + 2) begin : g_bad_packet_size
    $error("uart_rx: PACKET_SIZE must cover start, data and one stop bit");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic                 r_rx_d;
  logic                 w_fall;

  logic [CW-1:0]        r_clocks;
  logic [BW-1:0]        r_bits;
  logic [WW-1:0]        r_words;
  logic [BITS_PER_WORD-1:0] r_shift;
  logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] r_buf;
  logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] w_word;

  logic                 w_clk_run;
  logic                 w_shift;
  logic                 w_stop_ok;
  logic                 w_stop_bad;
  logic                 w_complete;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_d    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_d    <= r_rx_s;
    end
  end

  assign w_fall = r_rx_d & ~r_rx_s;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and per-cycle datapath controls.
  always_comb begin
    w_state_nxt = r_state;
    w_clk_run   = 1'b0;
    w_shift     = 1'b0;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_clk_run = 1'b1;
        if (r_clocks == c_HALF_LAST) begin
          w_clk_run = 1'b0;
          // A line back high at mid start bit was only a glitch.
          w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        w_clk_run = 1'b1;
        if (r_clocks == c_BIT_LAST) begin
          w_clk_run = 1'b0;
          w_shift   = 1'b1;
          if (r_bits == c_DATA_LAST) begin
            w_state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        w_clk_run = 1'b1;
        if (r_clocks == c_BIT_LAST) begin
          w_clk_run   = 1'b0;
          // Leave after the first stop bit so the next start edge is caught.
          w_state_nxt = S_IDLE;
          if (r_rx_s) begin
            w_stop_ok = 1'b1;
          end else begin
            w_stop_bad = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_complete = w_stop_ok && (r_words == c_WORD_LAST);

  // Full word as it would be with the byte just received in its slot.
  always_comb begin
    w_word          = r_buf;
    w_word[r_words] = r_shift;
  end

  // Bit-period timing and data-bit counting.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_clocks <= '0;
      r_bits   <= '0;
      r_shift  <= '0;
    end else begin
      r_clocks <= w_clk_run ? r_clocks + 1'b1 : '0;
      if (w_shift) begin
        r_shift <= {r_rx_s, r_shift[BITS_PER_WORD-1:1]};
        r_bits  <= (r_bits == c_DATA_LAST) ? '0 : r_bits + 1'b1;
      end
    end
  end

  // Word assembly across frames; a framing error drops the partial word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_words <= '0;
      r_buf   <= '0;
    end else if (w_stop_bad) begin
      r_words <= '0;
      r_buf   <= '0;
    end else if (w_stop_ok) begin
      r_buf[r_words] <= r_shift;
      r_words        <= w_complete ? '0 : r_words + 1'b1;
    end
  end

  // Output register with valid/ready handshake and status pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= w_stop_bad;
      overrun   <= 1'b0;
      if (w_complete) begin
        if (!m_valid || m_ready) begin
          m_data  <= w_word;
          m_valid <= 1'b1;
        end else begin
          // Held word is still pending: keep it and drop the new one.
          overrun <= 1'b1;
        end
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx with a scoreboard
//               queue of expected output words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CPP  = 4;
  localparam int BPW  = 8;
  localparam int PKT  = BPW + 5;
  localparam int WOUT = 24;
  localparam int NW   = WOUT / BPW;

  logic                    clk;
  logic                    rstn;
  logic                    rx;
  logic [NW-1:0][BPW-1:0]  m_data;
  logic                    m_valid;
  logic                    m_ready;
  logic                    frame_err;
  logic                    overrun;

  int total = 0;
  int bad   = 0;
  int n_ferr = 0;
  int n_ovr  = 0;
  int n_xfer = 0;
  logic [WOUT-1:0] exp_q[$];

  uart_rx #(
    .CLOCKS_PER_PULSE (CPP),
    .BITS_PER_WORD    (BPW),
    .PACKET_SIZE      (PKT),
    .W_OUT            (WOUT)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (rx),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: counts status pulses and scores every accepted word.
  always @(negedge clk) begin
    if (rstn) begin
      if (frame_err) n_ferr++;
      if (overrun)   n_ovr++;
      if (m_valid && m_ready) begin
        logic [WOUT-1:0] e;
        n_xfer++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $error("FAIL unexpected_xfer observed=%h expected=none", m_data);
        end else begin
          e = exp_q.pop_front();
          assert (m_data === e) else begin
            bad++;
            $error("FAIL xfer_data observed=%h expected=%h", m_data, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPP) tick();
  endtask

  // One frame: start, data LSB first, then PKT-BPW-1 stop bits.
  task automatic send_frame(input logic [BPW-1:0] d, input logic stop_ok);
    send_bit(1'b0);
    for (int i = 0; i < BPW; i++) send_bit(d[i]);
    send_bit(stop_ok);
    for (int i = 0; i < PKT - BPW - 2; i++) send_bit(1'b1);
  endtask

  task automatic send_word(input logic [WOUT-1:0] w);
    for (int i = 0; i < NW; i++) send_frame(w[i*BPW +: BPW], 1'b1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    int f0, o0, x0;
    rstn    = 1'b0;
    rx      = 1'b1;
    m_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_m_valid",   m_valid,   0);
    check("rst_m_data",    m_data,    0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun",   overrun,   0);
    rstn = 1'b1;
    repeat (5) tick();

    // 1: three frames make one word
    f0 = n_ferr; o0 = n_ovr; x0 = n_xfer;
    exp_q.push_back(24'h0F3CA5);
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    send_frame(8'h0F, 1'b1);
    wait_drain("t1_drain", 500);
    tick();
    check("t1_xfers",   n_xfer - x0, 1);
    check("t1_ferr",    n_ferr - f0, 0);
    check("t1_ovr",     n_ovr - o0,  0);
    check("t1_valid_low", m_valid,   0);

    // 2: repeated words with random idle gaps
    x0 = n_xfer;
    for (int r = 0; r < 10; r++) begin
      exp_q.push_back(24'h123456);
      send_word(24'h123456);
      repeat ($urandom_range(0, 6)) tick();
    end
    wait_drain("t2_drain", 500);
    check("t2_xfers", n_xfer - x0, 10);

    // 3: back-pressure, second word overruns
    m_ready = 1'b0;
    o0 = n_ovr; x0 = n_xfer;
    exp_q.push_back(24'h111111);
    send_word(24'h111111);
    send_word(24'h222222);
    check("t3_valid_held", m_valid, 1);
    check("t3_data_held",  m_data,  24'h111111);
    check("t3_ovr",        n_ovr - o0, 1);
    check("t3_no_xfer",    n_xfer - x0, 0);
    m_ready = 1'b1;
    repeat (3) tick();
    check("t3_xfers",     n_xfer - x0, 1);
    check("t3_valid_low", m_valid, 0);
    wait_drain("t3_drain", 10);

    // 4: bad stop bit on frame 1, then a clean word
    f0 = n_ferr; x0 = n_xfer;
    send_frame(8'h77, 1'b1);
    send_frame(8'h88, 1'b0);
    repeat (10) tick();
    check("t4_ferr",    n_ferr - f0, 1);
    check("t4_no_xfer", n_xfer - x0, 0);
    exp_q.push_back(24'hABCDEF);
    send_word(24'hABCDEF);
    wait_drain("t4_drain", 500);
    check("t4_xfers", n_xfer - x0, 1);

    // 5a: one-clock low glitch is ignored
    f0 = n_ferr; x0 = n_xfer;
    rx = 1'b0;
    tick();
    rx = 1'b1;
    repeat (20) tick();
    check("t5_glitch_xfer", n_xfer - x0, 0);
    check("t5_glitch_ferr", n_ferr - f0, 0);
    exp_q.push_back(24'hC3E1F0);
    send_word(24'hC3E1F0);
    wait_drain("t5_after_glitch", 500);

    // 5b: reset in the middle of the second frame's data bits
    m_ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rstn = 1'b0;
    #1;
    check("t5_rst_valid", m_valid,   0);
    check("t5_rst_data",  m_data,    0);
    check("t5_rst_ferr",  frame_err, 0);
    check("t5_rst_ovr",   overrun,   0);
    rx = 1'b1;
    repeat (3) tick();
    rstn    = 1'b1;
    m_ready = 1'b1;
    repeat (4) tick();
    x0 = n_xfer;
    exp_q.push_back(24'h3C96E7);
    send_word(24'h3C96E7);
    wait_drain("t5_after_rst", 500);
    check("t5_xfers", n_xfer - x0, 1);

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
